// File: rtl/twiddle_sequencer_pkg.sv
// Shared types and helpers for the R2^2 SDF twiddle sequencer.
//   tw_mark_t   : {en, first, last} marker carried down the latency delay line
//   seq_state_t : frame FSM state (IDLE between frames, RUN inside a frame)
//   tw_sel      : quadrant index -> twiddle multiplier (q0->0, q1->2, q2->1, q3->3)
//   tw_number   : sample count within a stage frame -> twiddle number for the table
package twiddle_sequencer_pkg;

  typedef struct packed {
    logic en;
    logic first;
    logic last;
  } tw_mark_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Bit-reversing the quadrant gives the R2^2 ordering of the twiddle exponents.
  function automatic logic [1:0] tw_sel(input logic [1:0] q);
    return {q[0], q[1]};
  endfunction

  // The low LOG_M-2 count bits give the index inside a quadrant, scaled up so a
  // smaller stage walks the full-size table in coarser steps. The product is
  // always below 2^LOG_N, so callers may truncate to LOG_N bits.
  function automatic logic [31:0] tw_number(input logic [31:0] count,
                                            input int log_n,
                                            input int log_m);
    logic [31:0] mask;
    logic [31:0] n;
    logic [1:0]  q;
    mask = (32'd1 << (log_m - 2)) - 32'd1;
    n    = (count & mask) << (log_n - log_m);
    q    = 2'((count >> (log_m - 2)) & 32'd3);
    return n * {30'd0, tw_sel(q)};
  endfunction

endpackage

// File: rtl/twiddle_sequencer_delay_line.sv
// Fixed-depth shift register used to align frame markers with the converted
// twiddle output. Shifts every cycle; a cycle without input pushes a bubble.
//   clock : master clock
//   reset : synchronous active-high reset, empties the line
//   clear : synchronous flush, empties the line
//   din   : value entering stage 0
//   dout  : value leaving the last stage (din itself when DEPTH is 0)
//   taps  : every stage, so the owner can see what is still in flight
module tw_delay_line
  import twiddle_sequencer_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter type T     = tw_mark_t
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  T     din,
  output T     dout,
  output T [(DEPTH > 0 ? DEPTH : 1)-1:0] taps
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
    assign taps = '0;
  end else begin : g_shift
    T [DEPTH-1:0] stages;

    // Stage 0 takes the new value, every other stage takes its predecessor.
    always_ff @(posedge clock) begin
      if (reset || clear) begin
        stages <= '0;
      end else begin
        stages[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stages[i] <= stages[i-1];
        end
      end
    end

    assign dout = stages[DEPTH-1];
    assign taps = stages;
  end

endmodule

// File: rtl/twiddle_sequencer.sv
// Twiddle sequencer for one R2^2 SDF stage: counts accepted samples within an
// M-point frame, issues the registered twiddle number to the table/converter
// pair, and delays the valid/first/last markers so they line up with the
// converted twiddle.
//   clock    : master clock
//   reset    : synchronous active-high reset (priority over clear)
//   clear    : synchronous abort; drops the frame and flushes the delay line
//   di_en    : input sample valid, one sample accepted per cycle
//   tw_addr  : twiddle number (registered, updates only on accepted samples)
//   tw_zero  : tw_addr is zero (multiplier bypass hint)
//   tc_en    : converted twiddle valid
//   tc_first : with tc_en, sample 0 of the frame
//   tc_last  : with tc_en, sample M-1 of the frame
//   busy     : frame in progress or markers still in flight
module twiddle_sequencer
  import twiddle_sequencer_pkg::*;
#(
  parameter int LOG_N = 6,
  parameter int LOG_M = 6,
  parameter int TW_FF = 1,
  parameter int TC_FF = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             di_en,
  output logic [LOG_N-1:0] tw_addr,
  output logic             tw_zero,
  output logic             tc_en,
  output logic             tc_first,
  output logic             tc_last,
  output logic             busy
);

  // One cycle for the tw_addr register plus the optional table/converter registers.
  localparam int L = 1 + TW_FF + TC_FF;

  logic [LOG_M-1:0] count;
  seq_state_t       state;
  logic [LOG_N-1:0] tw_next;
  logic             accept;
  logic             any_en;
  tw_mark_t         mark_in;
  tw_mark_t         mark_out;
  tw_mark_t [L-1:0] taps;

  // A sample that coincides with clear is dropped, so it never makes a marker.
  assign accept  = di_en & ~clear;
  assign tw_next = LOG_N'(tw_number(32'(count), LOG_N, LOG_M));

  assign mark_in.en    = accept;
  assign mark_in.first = accept & (count == '0);
  assign mark_in.last  = accept & (count == '1);

  // Counter, frame FSM and twiddle register all advance only on an accepted
  // sample; a stall simply holds everything. The last sample of a frame goes
  // back to IDLE, and the count wrap to zero lets the next sample restart RUN
  // without a gap cycle.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count   <= '0;
      state   <= IDLE;
      tw_addr <= '0;
      tw_zero <= 1'b1;
    end else if (di_en) begin
      count   <= count + 1'b1;
      tw_addr <= tw_next;
      tw_zero <= (tw_next == '0);
      case (state)
        IDLE:    state <= RUN;
        RUN:     state <= (count == '1) ? IDLE : RUN;
        default: state <= IDLE;
      endcase
    end
  end

  tw_delay_line #(
    .DEPTH (L),
    .T     (tw_mark_t)
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .din   (mark_in),
    .dout  (mark_out),
    .taps  (taps)
  );

  assign tc_en    = mark_out.en;
  assign tc_first = mark_out.first;
  assign tc_last  = mark_out.last;

  always_comb begin
    any_en = 1'b0;
    for (int i = 0; i < L; i++) begin
      any_en = any_en | taps[i].en;
    end
  end

  assign busy = (state == RUN) | any_en;

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Directed bench for twiddle_sequencer: a default stage (LOG_N=6, LOG_M=6, L=3),
// a small stage (LOG_M=4) and a zero-register variant (L=1).
module tb_twiddle_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       di_en = 1'b0;
  logic       di_en_b = 1'b0;
  logic       di_en_c = 1'b0;

  logic [5:0] tw_addr, tw_addr_b, tw_addr_c;
  logic       tw_zero, tw_zero_b, tw_zero_c;
  logic       tc_en, tc_en_b, tc_en_c;
  logic       tc_first, tc_first_b, tc_first_c;
  logic       tc_last, tc_last_b, tc_last_c;
  logic       busy, busy_b, busy_c;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  twiddle_sequencer #(.LOG_N(6), .LOG_M(6), .TW_FF(1), .TC_FF(1)) dut (
    .clock(clock), .reset(reset), .clear(clear), .di_en(di_en),
    .tw_addr(tw_addr), .tw_zero(tw_zero), .tc_en(tc_en),
    .tc_first(tc_first), .tc_last(tc_last), .busy(busy)
  );

  twiddle_sequencer #(.LOG_N(6), .LOG_M(4), .TW_FF(1), .TC_FF(1)) dut_b (
    .clock(clock), .reset(reset), .clear(1'b0), .di_en(di_en_b),
    .tw_addr(tw_addr_b), .tw_zero(tw_zero_b), .tc_en(tc_en_b),
    .tc_first(tc_first_b), .tc_last(tc_last_b), .busy(busy_b)
  );

  twiddle_sequencer #(.LOG_N(6), .LOG_M(6), .TW_FF(0), .TC_FF(0)) dut_c (
    .clock(clock), .reset(reset), .clear(1'b0), .di_en(di_en_c),
    .tw_addr(tw_addr_c), .tw_zero(tw_zero_c), .tc_en(tc_en_c),
    .tc_first(tc_first_c), .tc_last(tc_last_c), .busy(busy_c)
  );

  // One clock edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    di_en = 1'b0; di_en_b = 1'b0; di_en_c = 1'b0; clear = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    nvec++;
    if ({tw_addr, tw_zero, tc_en, tc_first, tc_last, busy} !== {6'd0, 1'b1, 4'b0000}) begin
      nerr++;
      $display("[TB] FAIL reset_state got addr=%0d zero=%b tc=%b%b%b busy=%b exp addr=0 zero=1 tc=000 busy=0",
               tw_addr, tw_zero, tc_en, tc_first, tc_last, busy);
    end
  endtask

  // 64 contiguous samples; markers expected 3 edges after each accept.
  task automatic test_full_frame;
    int chk_s [5] = '{16, 17, 33, 49, 63};
    int chk_v [5] = '{0, 2, 1, 3, 45};
    logic [2:0] exp_tc;
    do_reset();
    for (int s = 0; s < 68; s++) begin
      di_en = (s < 64);
      step();
      exp_tc = {(s >= 2 && s <= 65), (s == 2), (s == 65)};
      nvec++;
      if ({tc_en, tc_first, tc_last} !== exp_tc) begin
        nerr++;
        $display("[TB] FAIL full_frame_tc s=%0d got %b exp %b", s, {tc_en, tc_first, tc_last}, exp_tc);
      end
      nvec++;
      if (busy !== (s <= 65)) begin
        nerr++;
        $display("[TB] FAIL full_frame_busy s=%0d got %b exp %b", s, busy, (s <= 65));
      end
      for (int k = 0; k < 5; k++) begin
        if (s == chk_s[k]) begin
          nvec++;
          if (tw_addr !== 6'(chk_v[k]) || tw_zero !== (chk_v[k] == 0)) begin
            nerr++;
            $display("[TB] FAIL full_frame_tw count=%0d got addr=%0d zero=%b exp addr=%0d zero=%b",
                     s, tw_addr, tw_zero, chk_v[k], (chk_v[k] == 0));
          end
        end
      end
    end
    di_en = 1'b0;
  endtask

  // Five stall cycles once 20 samples are in; tc_en must show the same gap.
  task automatic test_stall;
    logic [2:0] mk [0:39];
    logic [2:0] exp_tc;
    logic [5:0] exp_tw;
    logic       en;
    int cnt;
    cnt = 0;
    do_reset();
    for (int s = 0; s < 37; s++) begin
      en = (s < 34) && !(s >= 20 && s < 25);
      mk[s] = {en, en && (cnt == 0), en && (cnt == 63)};
      if (en) cnt++;
      di_en = en;
      step();
      exp_tc = (s >= 2) ? mk[s-2] : 3'b000;
      nvec++;
      if ({tc_en, tc_first, tc_last} !== exp_tc) begin
        nerr++;
        $display("[TB] FAIL stall_tc s=%0d got %b exp %b", s, {tc_en, tc_first, tc_last}, exp_tc);
      end
      if (s >= 19 && s <= 25) begin
        exp_tw = (s == 25) ? 6'd8 : 6'd6;
        nvec++;
        if (tw_addr !== exp_tw || busy !== 1'b1) begin
          nerr++;
          $display("[TB] FAIL stall_hold s=%0d got addr=%0d busy=%b exp addr=%0d busy=1",
                   s, tw_addr, busy, exp_tw);
        end
      end
    end
    di_en = 1'b0;
  endtask

  // Two frames with no gap: last of frame 0 and first of frame 1 are adjacent.
  task automatic test_back_to_back;
    logic [2:0] exp_tc;
    do_reset();
    for (int s = 0; s < 132; s++) begin
      di_en = (s < 128);
      step();
      exp_tc = {(s >= 2 && s <= 129), (s == 2 || s == 66), (s == 65 || s == 129)};
      nvec++;
      if ({tc_en, tc_first, tc_last} !== exp_tc || busy !== (s <= 129)) begin
        nerr++;
        $display("[TB] FAIL back_to_back s=%0d got tc=%b busy=%b exp tc=%b busy=%b",
                 s, {tc_en, tc_first, tc_last}, busy, exp_tc, (s <= 129));
      end
      if (s == 127) begin
        nvec++;
        if (tw_addr !== 6'd45) begin
          nerr++;
          $display("[TB] FAIL back_to_back_tw got %0d exp 45", tw_addr);
        end
      end
    end
    di_en = 1'b0;
  endtask

  // Clear with di_en at count 40: sample dropped, line empty, new frame from 0.
  task automatic test_clear;
    do_reset();
    di_en = 1'b1;
    repeat (40) step();
    nvec++;
    if (tw_addr !== 6'd7) begin
      nerr++;
      $display("[TB] FAIL clear_pre_tw got %0d exp 7", tw_addr);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    nvec++;
    if ({tw_addr, tw_zero, tc_en, tc_first, tc_last, busy} !== {6'd0, 1'b1, 4'b0000}) begin
      nerr++;
      $display("[TB] FAIL clear_flush got addr=%0d zero=%b tc=%b%b%b busy=%b exp addr=0 zero=1 tc=000 busy=0",
               tw_addr, tw_zero, tc_en, tc_first, tc_last, busy);
    end
    for (int s = 0; s < 3; s++) begin
      di_en = (s == 0);
      step();
      nvec++;
      if ({tc_en, tc_first, tc_last} !== ((s == 2) ? 3'b110 : 3'b000)) begin
        nerr++;
        $display("[TB] FAIL clear_restart s=%0d got %b exp %b", s, {tc_en, tc_first, tc_last},
                 (s == 2) ? 3'b110 : 3'b000);
      end
    end
    di_en = 1'b0;
  endtask

  // Reset mid-frame at count 10: reset values next cycle, no stray markers.
  task automatic test_reset_mid_frame;
    do_reset();
    di_en = 1'b1;
    repeat (10) step();
    nvec++;
    if (tc_en !== 1'b1 || busy !== 1'b1) begin
      nerr++;
      $display("[TB] FAIL mid_frame_pre got tc_en=%b busy=%b exp 1 1", tc_en, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    di_en = 1'b0;
    nvec++;
    if ({tw_addr, tw_zero, tc_en, tc_first, tc_last, busy} !== {6'd0, 1'b1, 4'b0000}) begin
      nerr++;
      $display("[TB] FAIL mid_frame_reset got addr=%0d zero=%b tc=%b%b%b busy=%b exp addr=0 zero=1 tc=000 busy=0",
               tw_addr, tw_zero, tc_en, tc_first, tc_last, busy);
    end
    for (int s = 0; s < 3; s++) begin
      step();
      nvec++;
      if ({tc_en, tc_first, tc_last} !== 3'b000) begin
        nerr++;
        $display("[TB] FAIL mid_frame_quiet s=%0d got %b exp 000", s, {tc_en, tc_first, tc_last});
      end
    end
  endtask

  // LOG_M=4 stage: counts 5,7,10,15 -> 8,24,8,36; tc_last 3 edges after sample 15.
  task automatic test_small_stage;
    int chk_s [4] = '{5, 7, 10, 15};
    int chk_v [4] = '{8, 24, 8, 36};
    do_reset();
    for (int s = 0; s < 19; s++) begin
      di_en_b = (s < 16);
      step();
      for (int k = 0; k < 4; k++) begin
        if (s == chk_s[k]) begin
          nvec++;
          if (tw_addr_b !== 6'(chk_v[k])) begin
            nerr++;
            $display("[TB] FAIL small_stage_tw count=%0d got %0d exp %0d", s, tw_addr_b, chk_v[k]);
          end
        end
      end
      if (s == 17 || s == 18) begin
        nvec++;
        if ({tc_en_b, tc_last_b, busy_b} !== ((s == 17) ? 3'b111 : 3'b000)) begin
          nerr++;
          $display("[TB] FAIL small_stage_last s=%0d got %b exp %b", s, {tc_en_b, tc_last_b, busy_b},
                   (s == 17) ? 3'b111 : 3'b000);
        end
      end
    end
    di_en_b = 1'b0;
  endtask

  // No table/converter registers: tc_en one cycle after each accept.
  task automatic test_zero_latency;
    logic [9:0] pat;
    pat = 10'b0001001101;
    do_reset();
    for (int s = 0; s < 10; s++) begin
      di_en_c = pat[s];
      step();
      nvec++;
      if ({tc_en_c, tc_first_c} !== {pat[s], (s == 0)}) begin
        nerr++;
        $display("[TB] FAIL zero_latency s=%0d got %b%b exp %b%b", s, tc_en_c, tc_first_c, pat[s], (s == 0));
      end
    end
    di_en_c = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_back_to_back();
    test_clear();
    test_reset_mid_frame();
    test_small_stage();
    test_zero_latency();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
